// File: rtl/quad_step_decoder_if.sv
// quad_step_decoder_if: quadrature inputs and step/error outputs of quad_step_decoder.
// The master side drives the quadrature channels. The slave side (the decoder) drives
// the step, error and direction outputs.
interface quad_step_decoder_if;
   logic a_in;
   logic b_in;
   logic up;
   logic dn;
   logic err;
   logic dir;

   modport master (
      output a_in,
      output b_in,
      input  up,
      input  dn,
      input  err,
      input  dir
   );

   modport slave (
      input  a_in,
      input  b_in,
      output up,
      output dn,
      output err,
      output dir
   );
endinterface

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: synchronizes asynchronous quadrature channels A/B and decodes Gray-code
// transitions into mutually exclusive one-cycle up/dn pulses. A double-bit change is
// reported on err and is not counted.
// Optional glitch filter: define QUAD_STEP_FILTER_EN to build it in. Each channel must then
// hold a new level for FILTER_LEN cycles before it is accepted. Without the macro the
// synchronized inputs feed the decoder directly and FILTER_LEN has no effect.
module quad_step_decoder #(
   parameter int unsigned FILTER_LEN = 4
) (
   input logic                clk,
   input logic                rst,
   quad_step_decoder_if.slave qd_io
);

   typedef enum logic [0:0] {StInit, StTrack} state_e;

   // Stops elaboration if FILTER_LEN is outside 1..15, which the 4-bit filter counters need.
   if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : gen_bad_filter_len
      $error("quad_step_decoder: FILTER_LEN must be in 1..15");
   end

   // Position of {a,b} along the forward cycle 00 -> 10 -> 11 -> 01.
   function automatic logic [1:0] gray_pos(input logic [1:0] ab);
      logic [1:0] pos;
      case (ab)
         2'b00:   pos = 2'd0;
         2'b10:   pos = 2'd1;
         2'b11:   pos = 2'd2;
         default: pos = 2'd3;
      endcase
      return pos;
   endfunction

   // Bit 1 is channel A and bit 0 is channel B throughout.
   logic [1:0] s1_q, s1_d;
   logic [1:0] s2_q, s2_d;
   state_e     state_q, state_d;
   logic [1:0] init_cnt_q, init_cnt_d;
   logic [1:0] prev_q, prev_d;
   logic       up_q, up_d;
   logic       dn_q, dn_d;
   logic       err_q, err_d;
   logic       dir_q, dir_d;
   logic [1:0] cur;
   logic [1:0] step;

`ifdef QUAD_STEP_FILTER_EN
   localparam logic [3:0] FiltLenC = 4'(FILTER_LEN);

   logic [1:0]      f_q, f_d;
   logic [1:0][3:0] cnt_q, cnt_d;

   assign cur = f_q;
`else
   assign cur = s2_q;
`endif

   // Step distance modulo 4: 1 = forward, 3 = reverse, 2 = both bits changed.
   assign step = gray_pos(cur) - gray_pos(prev_q);

   // Next state for the synchronizer, the filter, the INIT/TRACK FSM and the registered outputs.
   always_comb begin
      s1_d       = {qd_io.a_in, qd_io.b_in};
      s2_d       = s1_q;
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      prev_d     = prev_q;
      up_d       = 1'b0;
      dn_d       = 1'b0;
      err_d      = 1'b0;
      dir_d      = dir_q;

`ifdef QUAD_STEP_FILTER_EN
      f_d   = f_q;
      cnt_d = cnt_q;
      for (int i = 0; i < 2; i++) begin
         if (s2_q[i] == f_q[i]) begin
            cnt_d[i] = 4'd0;
         end else if (cnt_q[i] == FiltLenC - 4'd1) begin
            // This edge would bring the counter to FILTER_LEN, so the new level is accepted.
            f_d[i]   = s2_q[i];
            cnt_d[i] = 4'd0;
         end else begin
            cnt_d[i] = cnt_q[i] + 4'd1;
         end
      end
`endif

      case (state_q)
         StInit: begin
            if (init_cnt_q == 2'd2) begin
               // Start tracking from the current input levels so that a non-zero
               // level at reset produces no event.
               state_d    = StTrack;
               init_cnt_d = 2'd0;
               prev_d     = s2_q;
`ifdef QUAD_STEP_FILTER_EN
               f_d   = s2_q;
               cnt_d = '0;
`endif
            end else begin
               init_cnt_d = init_cnt_q + 2'd1;
            end
         end
         StTrack: begin
            prev_d = cur;
            case (step)
               2'd1: begin
                  up_d  = 1'b1;
                  dir_d = 1'b1;
               end
               2'd3: begin
                  dn_d  = 1'b1;
                  dir_d = 1'b0;
               end
               2'd2:    err_d = 1'b1;
               default: ;
            endcase
         end
         default: state_d = StInit;
      endcase
   end

   // All state and outputs; rst clears them at once without waiting for a clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q       <= 2'b00;
         s2_q       <= 2'b00;
         state_q    <= StInit;
         init_cnt_q <= 2'd0;
         prev_q     <= 2'b00;
         up_q       <= 1'b0;
         dn_q       <= 1'b0;
         err_q      <= 1'b0;
         dir_q      <= 1'b1;
`ifdef QUAD_STEP_FILTER_EN
         f_q        <= 2'b00;
         cnt_q      <= '0;
`endif
      end else begin
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         prev_q     <= prev_d;
         up_q       <= up_d;
         dn_q       <= dn_d;
         err_q      <= err_d;
         dir_q      <= dir_d;
`ifdef QUAD_STEP_FILTER_EN
         f_q        <= f_d;
         cnt_q      <= cnt_d;
`endif
      end
   end

   assign qd_io.up  = up_q;
   assign qd_io.dn  = dn_q;
   assign qd_io.err = err_q;
   assign qd_io.dir = dir_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder: table of quadrature steps with hand-computed pulse counts, latency
// and direction, plus hand-written sequences for reset, glitch and mid-pulse reset cases.
// Expected latency follows QUAD_STEP_FILTER_EN in the same way as the design.
module tb_quad_step_decoder;

   localparam int unsigned FiltLen = 4;
`ifdef QUAD_STEP_FILTER_EN
   localparam int Lat    = FiltLen + 2;
   localparam bit FiltOn = 1'b1;
`else
   localparam int Lat    = 2;
   localparam bit FiltOn = 1'b0;
`endif

   typedef struct {
      logic a;
      logic b;
      int   hold;
      int   n_up;
      int   n_dn;
      int   n_err;
      logic dir;
      int   first;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   overlap = 0;

   quad_step_decoder_if qd ();

   quad_step_decoder #(.FILTER_LEN(FiltLen)) dut (
      .clk   (clk),
      .rst   (rst),
      .qd_io (qd)
   );

   always #5 clk = ~clk;

   // up and dn must never be high together.
   always @(negedge clk) begin
      if (qd.up && qd.dn) overlap++;
   end

   initial begin
      #100us;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   // Runs n edges; k = 0 is the first edge after the caller changed the inputs.
   task automatic run_cycles(input int n, output int nu, output int nd, output int ne,
                             output int first);
      nu = 0;
      nd = 0;
      ne = 0;
      first = -1;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         if (qd.up) nu++;
         if (qd.dn) nd++;
         if (qd.err) ne++;
         if ((qd.up || qd.dn || qd.err) && first < 0) first = k;
      end
   endtask

   // Pulses channel A high for width cycles starting from 00.
   task automatic pulse_a(input int width, output int nu, output int nd,
                          output int fu, output int fd);
      nu = 0;
      nd = 0;
      fu = -1;
      fd = -1;
      qd.a_in = 1'b1;
      for (int k = 0; k < width + 24; k++) begin
         @(posedge clk);
         #1;
         if (qd.up) begin
            nu++;
            if (fu < 0) fu = k;
         end
         if (qd.dn) begin
            nd++;
            if (fd < 0) fd = k;
         end
         if (k == width - 1) qd.a_in = 1'b0;
      end
   endtask

   initial begin
      vec_t tbl[14];
      int   nu, nd, ne, first, fu, fd;
      bit   found;

      tbl[0]  = '{1'b1, 1'b0, 10, 1, 0, 0, 1'b1, Lat};
      tbl[1]  = '{1'b1, 1'b1, 10, 1, 0, 0, 1'b1, Lat};
      tbl[2]  = '{1'b0, 1'b1, 10, 1, 0, 0, 1'b1, Lat};
      tbl[3]  = '{1'b0, 1'b0, 10, 1, 0, 0, 1'b1, Lat};
      tbl[4]  = '{1'b0, 1'b1, 10, 0, 1, 0, 1'b0, Lat};
      tbl[5]  = '{1'b1, 1'b1, 10, 0, 1, 0, 1'b0, Lat};
      tbl[6]  = '{1'b1, 1'b0, 10, 0, 1, 0, 1'b0, Lat};
      tbl[7]  = '{1'b0, 1'b0, 10, 0, 1, 0, 1'b0, Lat};
      tbl[8]  = '{1'b1, 1'b1, 10, 0, 0, 1, 1'b0, Lat};
      tbl[9]  = '{1'b0, 1'b1, 10, 1, 0, 0, 1'b1, Lat};
      tbl[10] = '{1'b0, 1'b0, 10, 1, 0, 0, 1'b1, Lat};
      tbl[11] = '{1'b0, 1'b0, 10, 0, 0, 0, 1'b1, -1};
      tbl[12] = '{1'b1, 1'b0, 10, 1, 0, 0, 1'b1, Lat};
      tbl[13] = '{1'b0, 1'b0, 10, 0, 1, 0, 1'b0, Lat};

      // Reset held with inputs at 11: reset values, then silence through INIT and beyond.
      qd.a_in = 1'b1;
      qd.b_in = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_up", int'(qd.up), 0);
      check("rst_dn", int'(qd.dn), 0);
      check("rst_err", int'(qd.err), 0);
      check("rst_dir", int'(qd.dir), 1);
      rst = 1'b0;
      run_cycles(25, nu, nd, ne, first);
      check("init11_up", nu, 0);
      check("init11_dn", nd, 0);
      check("init11_err", ne, 0);

      // Restart from 00 for the step table.
      rst = 1'b1;
      qd.a_in = 1'b0;
      qd.b_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      run_cycles(10, nu, nd, ne, first);
      check("init00_events", nu + nd + ne, 0);

      for (int i = 0; i < 14; i++) begin
         qd.a_in = tbl[i].a;
         qd.b_in = tbl[i].b;
         run_cycles(tbl[i].hold, nu, nd, ne, first);
         check($sformatf("row%0d_up", i), nu, tbl[i].n_up);
         check($sformatf("row%0d_dn", i), nd, tbl[i].n_dn);
         check($sformatf("row%0d_err", i), ne, tbl[i].n_err);
         check($sformatf("row%0d_dir", i), int'(qd.dir), int'(tbl[i].dir));
         check($sformatf("row%0d_latency", i), first, tbl[i].first);
      end

      // Short glitch on A: rejected by the filter, passed as up then dn without it.
      pulse_a(3, nu, nd, fu, fd);
      check("glitch3_up", nu, FiltOn ? 0 : 1);
      check("glitch3_dn", nd, FiltOn ? 0 : 1);

      // Wide pulse on A: always one up, then one dn.
      pulse_a(6, nu, nd, fu, fd);
      check("pulse6_up", nu, 1);
      check("pulse6_dn", nd, 1);
      check("pulse6_up_at", fu, Lat);
      check("pulse6_dn_at", fd, 6 + Lat);
      check("pulse6_dir", int'(qd.dir), 0);

      // Reset asserted while up is high: outputs clear without a clock edge.
      qd.a_in = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(posedge clk);
         #1;
         if (qd.up) found = 1'b1;
      end
      check("midrst_up_seen", int'(found), 1);
      rst = 1'b1;
      #1;
      check("midrst_up_async", int'(qd.up), 0);
      check("midrst_dir_async", int'(qd.dir), 1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      run_cycles(3, nu, nd, ne, first);
      check("midrst_init_events", nu + nd + ne, 0);
      run_cycles(20, nu, nd, ne, first);
      check("midrst_steady_events", nu + nd + ne, 0);
      qd.b_in = 1'b1;
      run_cycles(10, nu, nd, ne, first);
      check("midrst_step_up", nu, 1);
      check("midrst_step_latency", first, Lat);
      check("midrst_step_dir", int'(qd.dir), 1);

      check("up_dn_exclusive", overlap, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/quad_step_decoder.md
# quad_step_decoder

Upstream stage of the signed up/down counter. It converts a pair of asynchronous quadrature inputs (`a_in`, `b_in`) into mutually exclusive single-cycle `up` / `dn` step pulses that drive the counter's `up` / `dn` ports directly. It synchronizes both inputs, optionally glitch-filters them, and decodes Gray-code transitions. Illegal double-bit transitions are flagged rather than counted.

## Interface
- `FILTER_LEN`, 4: consecutive cycles a synchronized input must hold a new level before it is accepted; legal range 1..15. Used only when the filter is compiled in.
- `clk`  input  1  system clock, all logic on the rising edge
- `rst`  input  1  asynchronous, active-high reset
- `a_in`  input  1  quadrature channel A, asynchronous to `clk`
- `b_in`  input  1  quadrature channel B, asynchronous to `clk`
- `up`  output  1  one-cycle pulse per forward step
- `dn`  output  1  one-cycle pulse per reverse step
- `err`  output  1  one-cycle pulse on an illegal transition (both channels changed)
- `dir`  output  1  sticky direction of the last legal step: 1 = forward, 0 = reverse

## Operation
- **Synchronizer:** two flops per channel (`s1`, `s2`), both reset to 0.
- **Filter (when compiled in):** one counter per channel; the filtered value `x_f` is reset to 0.
  - The counter increments on each edge where `s2 != x_f`.
  - It clears on any edge where `s2 == x_f`.
  - On the edge where the counter would reach `FILTER_LEN`, `x_f <= s2` and the counter clears.
- **State machine:** two states, INIT and TRACK; reset forces INIT.
  - INIT: a 2-bit counter runs for 3 edges after `rst` deasserts. On the third edge it loads `a_f`, `b_f` and `prev` directly from `s2`, bypassing the filter, and enters TRACK. No `up`, `dn` or `err` is produced in INIT.
  - TRACK: each edge compares `cur = {a_f, b_f}` with `prev`, then sets `prev <= cur`.
- **Decoding of `cur` against `prev`:**
  - Forward cycle is 00 → 10 → 11 → 01 → 00; each forward step gives `up` = 1 and `dir` = 1.
  - Reverse of that cycle gives `dn` = 1 and `dir` = 0.
  - Both bits changed gives `err` = 1; `up`, `dn` and `dir` are unchanged, and `prev` still updates.
  - No change gives no pulse.
- `up` and `dn` are never high in the same cycle; this is required by the downstream counter.
- All outputs are registered.
- Reset values: `up` = 0, `dn` = 0, `err` = 0, `dir` = 1.

## Timing
Edges are counted from the first `clk` edge that samples the new input level into `s1` (E0).
- Filter in: `x_f` updates at E(1+FILTER_LEN); the pulse is high in the cycle after E(2+FILTER_LEN). With the default, the pulse follows E6.
- Filter out: `x_f` is `s2`; the pulse is high in the cycle after E2.
- Every pulse lasts exactly one cycle.
- Maximum legal step rate is one step per `FILTER_LEN` + 1 cycles with the filter in, or one per cycle with it out. Faster input may produce `err`.
- If both channels' filters accept on the same edge, the result is a both-bits change and gives `err`.
- Asserting `rst` mid-operation clears all outputs immediately, without waiting for a clock edge. The block then re-enters INIT, and no event is produced until TRACK is reached.

## Configuration
- `QUAD_STEP_FILTER_EN` defined: the per-channel glitch filter and `FILTER_LEN` counters are built in.
- `QUAD_STEP_FILTER_EN` undefined: `a_f` = `a_s2` and `b_f` = `b_s2`, `FILTER_LEN` is ignored, and latency drops to 2 edges.
- The INIT sequence is identical in both builds.

## Test plan
All scenarios use `FILTER_LEN` = 4 with the filter in, unless stated otherwise.
- **Reset with non-zero inputs:** hold `a_in` = `b_in` = 1 through reset, then release. Required: no `up`, `dn` or `err` during INIT or afterwards while inputs stay at 11.
- **Forward steps:** from 00, step 10, 11, 01, 00, holding each level 10 cycles. Required: exactly 4 `up` pulses, each after E6 of its input change; `dn` = 0 and `err` = 0 throughout; `dir` = 1.
- **Reverse steps:** from 00, step 01, 11, 10, 00. Required: exactly 4 `dn` pulses; `up` = 0; `dir` = 0.
- **Glitch filtering:** pulse `a_in` high for 3 cycles from 00. Required: no event. Then pulse it high for 6 cycles. Required: one `up` followed by one `dn`.
- **Illegal transition:** toggle both inputs on the same cycle, 00 → 11. Required: one `err` pulse; no `up` or `dn`; `dir` unchanged. A following 11 → 01 step gives one `up`.
- **Reset mid-pulse:** assert `rst` in the cycle `up` is high. Required: `up` drops immediately without a clock edge. After release, no events for 3 edges. Repeat the forward-step scenario with `QUAD_STEP_FILTER_EN` undefined; required: each pulse follows E2.
